// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: receive side of a multiplexed 7-segment scan.
// Samples an/seg, waits for each scan slot to settle and decodes the glyph back into a hex nibble.
// It then rebuilds the 4-digit value and flags bad glyphs and overlapping anodes.
// Optional stale-display watchdog: define SEG7_CAPTURE_STALE_EN.
module seg7_scan_capture #(
    parameter int STABLE_CYCLES = 4,
    parameter bit ACTIVE_LOW    = 1'b1,
    parameter int STALE_CYCLES  = 2**20
) (
    input  logic        clk,
    input  logic        btnC,
    input  logic [3:0]  an,
    input  logic [6:0]  seg,
    output logic [15:0] digits,
    output logic [3:0]  digit_valid,
    output logic [3:0]  bad_pattern,
    output logic        frame_done,
    output logic        multi_anode_err
);

    localparam int              CW       = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_MAX  = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0]   CNT_PRE  = CW'(STABLE_CYCLES - 1);
    // Inactive pin level, so a fresh reset never looks like a lit digit
    localparam logic [10:0]     IDLE_LVL = ACTIVE_LOW ? 11'h7FF : 11'h000;

    // Glyph lookup on active-low segment codes {g,f,e,d,c,b,a}; returns {hit, nibble}
    function automatic logic [4:0] decode_glyph(input logic [6:0] code);
        logic [4:0] r;
        case (code)
            7'b1000000: r = {1'b1, 4'h0};
            7'b1111001: r = {1'b1, 4'h1};
            7'b0100100: r = {1'b1, 4'h2};
            7'b0110000: r = {1'b1, 4'h3};
            7'b0011001: r = {1'b1, 4'h4};
            7'b0010010: r = {1'b1, 4'h5};
            7'b0000010: r = {1'b1, 4'h6};
            7'b1111000: r = {1'b1, 4'h7};
            7'b0000000: r = {1'b1, 4'h8};
            7'b0010000: r = {1'b1, 4'h9};
            7'b0001000: r = {1'b1, 4'hA};
            7'b0000011: r = {1'b1, 4'hB};
            7'b1000110: r = {1'b1, 4'hC};
            7'b0100001: r = {1'b1, 4'hD};
            7'b0000110: r = {1'b1, 4'hE};
            7'b0001110: r = {1'b1, 4'hF};
            default:    r = {1'b0, 4'h0};
        endcase
        return r;
    endfunction

    logic [10:0]   sync1_q, sync1_d, sync2_q, sync2_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   digits_q, digits_d;
    logic [3:0]    valid_q, valid_d;
    logic [3:0]    bad_q, bad_d;
    logic [3:0]    seen_q, seen_d;
    logic          frame_done_q, frame_done_d;
    logic          multi_q, multi_d;

    logic [10:0]   samp_n;
    logic [3:0]    an_act;
    logic [6:0]    seg_code;
    logic          capture;
    logic [1:0]    idx;

`ifdef SEG7_CAPTURE_STALE_EN
    localparam int            SW        = $clog2(STALE_CYCLES + 1);
    localparam logic [SW-1:0] STALE_PRE = SW'(STALE_CYCLES - 1);
    logic [SW-1:0] stale_q, stale_d;
`else
    // No watchdog in this build; the empty block only keeps STALE_CYCLES referenced
    if (STALE_CYCLES < 1) begin : g_stale_cfg_unused
    end
`endif

    // Synchronizer inputs and polarity normalisation (active-high internally after sync)
    always_comb begin
        sync1_d  = {an, seg};
        sync2_d  = sync1_q;
        samp_n   = ACTIVE_LOW ? ~sync2_q : sync2_q;
        an_act   = samp_n[10:7];
        seg_code = ~samp_n[6:0];
    end

    // Stability counter: the sample entering the second flop is compared with the settled one,
    // so the window closes 2 + STABLE_CYCLES clocks after a pin change
    always_comb begin
        cnt_d   = cnt_q;
        capture = 1'b0;
        if (sync1_q != sync2_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d   = cnt_q + 1'b1;
            capture = (cnt_q == CNT_PRE);
        end
    end

    // Index of the single active anode (only meaningful when exactly one is lit)
    always_comb begin
        idx = 2'd0;
        for (int k = 0; k < 4; k++) begin
            if (an_act[k]) idx = 2'(k);
        end
    end

    // Capture update: glyph decode, seen-mask/frame tracking, anode overlap and optional watchdog
    always_comb begin
        logic [4:0] dec;
        logic [3:0] seen_new;
        digits_d     = digits_q;
        valid_d      = valid_q;
        bad_d        = bad_q;
        seen_d       = seen_q;
        multi_d      = multi_q;
        frame_done_d = 1'b0;
        dec          = decode_glyph(seg_code);
        seen_new     = seen_q;
        if (capture) begin
            if ($onehot(an_act)) begin
                if (dec[4]) begin
                    digits_d[4*idx +: 4] = dec[3:0];
                    valid_d[idx]         = 1'b1;
                    bad_d[idx]           = 1'b0;
                end else begin
                    valid_d[idx] = 1'b0;
                    bad_d[idx]   = 1'b1;
                end
                seen_new = seen_q | an_act;
                if (seen_new == 4'hF) begin
                    frame_done_d = 1'b1;
                    seen_d       = 4'h0;
                end else begin
                    seen_d = seen_new;
                end
            end else if (an_act != 4'h0) begin
                multi_d = 1'b1;
            end
        end
`ifdef SEG7_CAPTURE_STALE_EN
        stale_d = stale_q + 1'b1;
        if (frame_done_d) begin
            stale_d = '0;
        end else if (stale_q == STALE_PRE) begin
            stale_d = '0;
            valid_d = 4'h0;
        end
`endif
    end

    // State registers, asynchronously cleared by btnC low
    always_ff @(posedge clk or negedge btnC) begin
        if (!btnC) begin
            sync1_q      <= IDLE_LVL;
            sync2_q      <= IDLE_LVL;
            cnt_q        <= '0;
            digits_q     <= 16'h0;
            valid_q      <= 4'h0;
            bad_q        <= 4'h0;
            seen_q       <= 4'h0;
            frame_done_q <= 1'b0;
            multi_q      <= 1'b0;
`ifdef SEG7_CAPTURE_STALE_EN
            stale_q      <= '0;
`endif
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            cnt_q        <= cnt_d;
            digits_q     <= digits_d;
            valid_q      <= valid_d;
            bad_q        <= bad_d;
            seen_q       <= seen_d;
            frame_done_q <= frame_done_d;
            multi_q      <= multi_d;
`ifdef SEG7_CAPTURE_STALE_EN
            stale_q      <= stale_d;
`endif
        end
    end

    assign digits          = digits_q;
    assign digit_valid     = valid_q;
    assign bad_pattern     = bad_q;
    assign frame_done      = frame_done_q;
    assign multi_anode_err = multi_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture (STABLE_CYCLES=4, active-low pins, STALE_CYCLES=64).
module tb_seg7_scan_capture;

    logic        clk = 1'b0;
    logic        btnC = 1'b0;
    logic [3:0]  an = 4'hF;
    logic [6:0]  seg = 7'h7F;
    logic [15:0] digits;
    logic [3:0]  digit_valid;
    logic [3:0]  bad_pattern;
    logic        frame_done;
    logic        multi_anode_err;

    int checks = 0;
    int errors = 0;
    int fd_cnt = 0;

    localparam logic [6:0] G0 = 7'b1000000;
    localparam logic [6:0] G1 = 7'b1111001;
    localparam logic [6:0] G2 = 7'b0100100;
    localparam logic [6:0] G3 = 7'b0110000;
    localparam logic [6:0] G4 = 7'b0011001;
    localparam logic [6:0] BLANK = 7'b1111111;

    seg7_scan_capture #(
        .STABLE_CYCLES(4),
        .ACTIVE_LOW(1'b1),
        .STALE_CYCLES(64)
    ) dut (
        .clk(clk),
        .btnC(btnC),
        .an(an),
        .seg(seg),
        .digits(digits),
        .digit_valid(digit_valid),
        .bad_pattern(bad_pattern),
        .frame_done(frame_done),
        .multi_anode_err(multi_anode_err)
    );

    always #5 clk = ~clk;

    // Count frame pulses just after each rising edge
    always @(posedge clk) begin
        #1;
        if (frame_done) fd_cnt++;
    end

    // Caller sits at a negedge; pins change here and n clock edges elapse
    task automatic slot(input logic [3:0] a, input logic [6:0] s, input int n);
        an  = a;
        seg = s;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        btnC = 1'b0;
        an = 4'hF; seg = BLANK;
        repeat (3) @(negedge clk);
        checks++;
        if ({digits, digit_valid, bad_pattern, frame_done, multi_anode_err} !== 26'h0) begin
            errors++;
            $display("FAIL reset_state got %h/%h/%h/%b/%b want 0", digits, digit_valid, bad_pattern, frame_done, multi_anode_err);
        end
        btnC = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_scan_1234;
        int fd0;
        fd0 = fd_cnt;
        slot(4'b1110, G4, 5);
        checks++;
        if (digit_valid !== 4'b0000) begin
            errors++;
            $display("FAIL latency_early valid got %b want 0000", digit_valid);
        end
        slot(4'b1110, G4, 1);
        checks++;
        if (digit_valid !== 4'b0001 || digits[3:0] !== 4'h4) begin
            errors++;
            $display("FAIL latency_capture valid got %b digit0 %h want 0001 4", digit_valid, digits[3:0]);
        end
        slot(4'b1110, G4, 2);
        slot(4'b1101, G3, 8);
        slot(4'b1011, G2, 8);
        checks++;
        if (fd_cnt !== fd0) begin
            errors++;
            $display("FAIL early_frame pulses got %0d want %0d", fd_cnt, fd0);
        end
        slot(4'b0111, G1, 8);
        checks++;
        if (digits !== 16'h1234 || digit_valid !== 4'hF || bad_pattern !== 4'h0) begin
            errors++;
            $display("FAIL scan_1234 got %h/%h/%h want 1234/f/0", digits, digit_valid, bad_pattern);
        end
        checks++;
        if (fd_cnt !== fd0 + 1) begin
            errors++;
            $display("FAIL frame_pulse count got %0d want %0d", fd_cnt, fd0 + 1);
        end
        // Holding the same slot must not re-capture or pulse again
        slot(4'b0111, G1, 8);
        checks++;
        if (fd_cnt !== fd0 + 1) begin
            errors++;
            $display("FAIL hold_no_recapture pulses got %0d want %0d", fd_cnt, fd0 + 1);
        end
    endtask

    task automatic test_glitch;
        int fd0;
        fd0 = fd_cnt;
        slot(4'b1110, G0, 3);
        slot(4'b1111, BLANK, 8);
        checks++;
        if (digits !== 16'h1234 || digit_valid !== 4'hF) begin
            errors++;
            $display("FAIL glitch_update got %h/%h want 1234/f", digits, digit_valid);
        end
        slot(4'b1101, G3, 8);
        slot(4'b1011, G2, 8);
        slot(4'b0111, G1, 8);
        checks++;
        if (fd_cnt !== fd0) begin
            errors++;
            $display("FAIL glitch_seen pulses got %0d want %0d", fd_cnt, fd0);
        end
        slot(4'b1110, G4, 8);
        checks++;
        if (fd_cnt !== fd0 + 1) begin
            errors++;
            $display("FAIL glitch_then_frame pulses got %0d want %0d", fd_cnt, fd0 + 1);
        end
    endtask

    task automatic test_bad_glyph;
        slot(4'b1011, BLANK, 8);
        checks++;
        if (bad_pattern !== 4'b0100 || digit_valid !== 4'b1011 || digits !== 16'h1234) begin
            errors++;
            $display("FAIL bad_glyph got %h/%b/%b want 1234/1011/0100", digits, digit_valid, bad_pattern);
        end
        slot(4'b1011, G2, 8);
        checks++;
        if (bad_pattern !== 4'b0000 || digit_valid !== 4'hF) begin
            errors++;
            $display("FAIL bad_recover got %b/%b want 1111/0000", digit_valid, bad_pattern);
        end
    endtask

    task automatic test_multi_anode;
        slot(4'b1100, G4, 8);
        checks++;
        if (multi_anode_err !== 1'b1 || digits !== 16'h1234 || digit_valid !== 4'hF) begin
            errors++;
            $display("FAIL multi_anode got %b/%h/%h want 1/1234/f", multi_anode_err, digits, digit_valid);
        end
        slot(4'b1110, G0, 8);
        checks++;
        if (multi_anode_err !== 1'b1 || digits !== 16'h1230) begin
            errors++;
            $display("FAIL multi_sticky got %b/%h want 1/1230", multi_anode_err, digits);
        end
    endtask

    task automatic test_reset_mid;
        slot(4'b1101, G3, 2);
        #2 btnC = 1'b0;
        #1;
        checks++;
        if ({digits, digit_valid, bad_pattern, frame_done, multi_anode_err} !== 26'h0) begin
            errors++;
            $display("FAIL async_reset got %h/%h/%h/%b/%b want 0", digits, digit_valid, bad_pattern, frame_done, multi_anode_err);
        end
        @(negedge clk);
        btnC = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (digit_valid !== 4'b0000) begin
            errors++;
            $display("FAIL reset_partial_window valid got %b want 0000", digit_valid);
        end
        @(negedge clk);
        checks++;
        if (digit_valid !== 4'b0010 || digits !== 16'h0030) begin
            errors++;
            $display("FAIL reset_resume got %b/%h want 0010/0030", digit_valid, digits);
        end
    endtask

`ifdef SEG7_CAPTURE_STALE_EN
    task automatic test_stale;
        bit got;
        btnC = 1'b0;
        @(negedge clk);
        btnC = 1'b1;
        slot(4'b1110, G4, 8);
        slot(4'b1101, G3, 8);
        slot(4'b1011, G2, 8);
        an = 4'b0111; seg = G1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = frame_done;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL stale_frame frame_done got 0 want 1");
        end
        slot(4'b1111, BLANK, 63);
        checks++;
        if (digit_valid !== 4'hF) begin
            errors++;
            $display("FAIL stale_early valid got %b want 1111", digit_valid);
        end
        slot(4'b1111, BLANK, 1);
        checks++;
        if (digit_valid !== 4'h0 || digits !== 16'h1234) begin
            errors++;
            $display("FAIL stale_clear got %b/%h want 0000/1234", digit_valid, digits);
        end
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset;
        test_scan_1234;
        test_glitch;
        test_bad_glyph;
        test_multi_anode;
        test_reset_mid;
`ifdef SEG7_CAPTURE_STALE_EN
        test_stale;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
